// File: rtl/reorder_buffer_if.sv
// Decoder, execution-unit and register-file connections of the reorder buffer.
interface reorder_buffer_if;
    logic        issue;
    logic [4:0]  issue_rd;
    logic [1:0]  issue_type;
    logic        issue_pred_jump;
    logic [31:0] issue_pc;
    logic [3:0]  issue_rob_pos;
    logic        rob_full;

    logic        alu_result;
    logic [3:0]  alu_rob_pos;
    logic [31:0] alu_val;
    logic        alu_jump;
    logic [31:0] alu_target_pc;

    logic        lsb_result;
    logic [3:0]  lsb_rob_pos;
    logic [31:0] lsb_val;

    logic [3:0]  rs1_rob_pos;
    logic [3:0]  rs2_rob_pos;
    logic        rs1_ready;
    logic        rs2_ready;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;

    logic        commit;
    logic [4:0]  commit_rd;
    logic [31:0] commit_val;
    logic [3:0]  commit_rob_pos;
    logic        commit_store;
    logic        rollback;
    logic [31:0] rollback_pc;

    modport master (
        output issue, issue_rd, issue_type, issue_pred_jump, issue_pc,
        output alu_result, alu_rob_pos, alu_val, alu_jump, alu_target_pc,
        output lsb_result, lsb_rob_pos, lsb_val,
        output rs1_rob_pos, rs2_rob_pos,
        input  issue_rob_pos, rob_full, rs1_ready, rs2_ready, rs1_val, rs2_val,
        input  commit, commit_rd, commit_val, commit_rob_pos, commit_store,
        input  rollback, rollback_pc
    );

    modport slave (
        input  issue, issue_rd, issue_type, issue_pred_jump, issue_pc,
        input  alu_result, alu_rob_pos, alu_val, alu_jump, alu_target_pc,
        input  lsb_result, lsb_rob_pos, lsb_val,
        input  rs1_rob_pos, rs2_rob_pos,
        output issue_rob_pos, rob_full, rs1_ready, rs2_ready, rs1_val, rs2_val,
        output commit, commit_rd, commit_val, commit_rob_pos, commit_store,
        output rollback, rollback_pc
    );
endinterface

// File: rtl/reorder_buffer.sv
// In-order retirement buffer: allocates entries at issue, collects ALU/LSB write-backs,
// retires the head entry each cycle and flushes everything on a branch misprediction.
module reorder_buffer #(
    parameter int ROB_SIZE = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            rdy,
    reorder_buffer_if.slave rob
);
    localparam logic [1:0] TYPE_REG   = 2'b00;
    localparam logic [1:0] TYPE_BR    = 2'b01;
    localparam logic [1:0] TYPE_STORE = 2'b10;
    localparam logic [4:0] CAP        = 5'(ROB_SIZE);
    localparam logic [4:0] FULL_MARK  = 5'(ROB_SIZE - 1);
    localparam logic [3:0] LAST_POS   = 4'(ROB_SIZE - 1);

    logic [ROB_SIZE-1:0] valid_r;
    logic [ROB_SIZE-1:0] ready_r;
    logic [ROB_SIZE-1:0] pred_r;
    logic [ROB_SIZE-1:0] jump_r;
    logic [4:0]          rd_r     [ROB_SIZE];
    logic [1:0]          type_r   [ROB_SIZE];
    logic [31:0]         pc_r     [ROB_SIZE];
    logic [31:0]         val_r    [ROB_SIZE];
    logic [31:0]         target_r [ROB_SIZE];

    logic [3:0]  head_r;
    logic [3:0]  tail_r;
    logic [4:0]  count_r;

    logic        commit_r;
    logic [4:0]  commit_rd_r;
    logic [31:0] commit_val_r;
    logic [3:0]  commit_rob_pos_r;
    logic        commit_store_r;
    logic        rollback_r;
    logic [31:0] rollback_pc_r;

    logic        issue_ok_s;
    logic        retire_s;
    logic        mispred_s;
    logic        alu_wb_s;
    logic        lsb_wb_s;
    logic        rs1_ready_s;
    logic        rs2_ready_s;
    logic [31:0] rs1_val_s;
    logic [31:0] rs2_val_s;

    function automatic logic [3:0] ptr_inc(input logic [3:0] p);
        if (p == LAST_POS) begin
            return 4'd0;
        end else begin
            return p + 4'd1;
        end
    endfunction

    // Per-cycle qualification of issue, write-back and retirement.
    always_comb begin
        issue_ok_s = rdy & rob.issue & (count_r < CAP) & ~rollback_r;
        retire_s   = rdy & valid_r[head_r] & ready_r[head_r];
        mispred_s  = retire_s & (type_r[head_r] == TYPE_BR) & (jump_r[head_r] != pred_r[head_r]);
        alu_wb_s   = rdy & ~rollback_r & rob.alu_result & valid_r[rob.alu_rob_pos];
        // The ALU owns a position both units target in the same cycle.
        lsb_wb_s   = rdy & ~rollback_r & rob.lsb_result & valid_r[rob.lsb_rob_pos]
                     & ~(rob.alu_result & (rob.alu_rob_pos == rob.lsb_rob_pos));
    end

    // Operand lookup: stored result first, then same-cycle ALU, then same-cycle LSB bypass.
    always_comb begin
        rs1_ready_s = 1'b0;
        rs1_val_s   = 32'd0;
        rs2_ready_s = 1'b0;
        rs2_val_s   = 32'd0;
        if (ready_r[rob.rs1_rob_pos]) begin
            rs1_ready_s = 1'b1;
            rs1_val_s   = val_r[rob.rs1_rob_pos];
        end else if (rob.alu_result && (rob.alu_rob_pos == rob.rs1_rob_pos)) begin
            rs1_ready_s = 1'b1;
            rs1_val_s   = rob.alu_val;
        end else if (rob.lsb_result && (rob.lsb_rob_pos == rob.rs1_rob_pos)) begin
            rs1_ready_s = 1'b1;
            rs1_val_s   = rob.lsb_val;
        end else begin
            rs1_ready_s = 1'b0;
            rs1_val_s   = 32'd0;
        end
        if (ready_r[rob.rs2_rob_pos]) begin
            rs2_ready_s = 1'b1;
            rs2_val_s   = val_r[rob.rs2_rob_pos];
        end else if (rob.alu_result && (rob.alu_rob_pos == rob.rs2_rob_pos)) begin
            rs2_ready_s = 1'b1;
            rs2_val_s   = rob.alu_val;
        end else if (rob.lsb_result && (rob.lsb_rob_pos == rob.rs2_rob_pos)) begin
            rs2_ready_s = 1'b1;
            rs2_val_s   = rob.lsb_val;
        end else begin
            rs2_ready_s = 1'b0;
            rs2_val_s   = 32'd0;
        end
    end

    // Entry storage, pointers and registered commit/rollback outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_r <= '0;
            ready_r <= '0;
            pred_r  <= '0;
            jump_r  <= '0;
            for (int i = 0; i < ROB_SIZE; i++) begin
                rd_r[i]     <= 5'd0;
                type_r[i]   <= 2'b00;
                pc_r[i]     <= 32'd0;
                val_r[i]    <= 32'd0;
                target_r[i] <= 32'd0;
            end
            head_r           <= 4'd0;
            tail_r           <= 4'd0;
            count_r          <= 5'd0;
            commit_r         <= 1'b0;
            commit_rd_r      <= 5'd0;
            commit_val_r     <= 32'd0;
            commit_rob_pos_r <= 4'd0;
            commit_store_r   <= 1'b0;
            rollback_r       <= 1'b0;
            rollback_pc_r    <= 32'd0;
        end else if (rdy) begin
            commit_r       <= 1'b0;
            commit_store_r <= 1'b0;
            rollback_r     <= 1'b0;
            if (mispred_s) begin
                // Misprediction squashes every younger entry, including this cycle's issue.
                valid_r       <= '0;
                ready_r       <= '0;
                head_r        <= 4'd0;
                tail_r        <= 4'd0;
                count_r       <= 5'd0;
                rollback_r    <= 1'b1;
                rollback_pc_r <= jump_r[head_r] ? target_r[head_r] : pc_r[head_r] + 32'd4;
            end else begin
                if (issue_ok_s) begin
                    valid_r[tail_r] <= 1'b1;
                    ready_r[tail_r] <= 1'b0;
                    pred_r[tail_r]  <= rob.issue_pred_jump;
                    jump_r[tail_r]  <= 1'b0;
                    rd_r[tail_r]    <= rob.issue_rd;
                    type_r[tail_r]  <= rob.issue_type;
                    pc_r[tail_r]    <= rob.issue_pc;
                    tail_r          <= ptr_inc(tail_r);
                end
                if (lsb_wb_s) begin
                    ready_r[rob.lsb_rob_pos] <= 1'b1;
                    val_r[rob.lsb_rob_pos]   <= rob.lsb_val;
                end
                if (alu_wb_s) begin
                    ready_r[rob.alu_rob_pos]  <= 1'b1;
                    val_r[rob.alu_rob_pos]    <= rob.alu_val;
                    jump_r[rob.alu_rob_pos]   <= rob.alu_jump;
                    target_r[rob.alu_rob_pos] <= rob.alu_target_pc;
                end
                if (retire_s) begin
                    valid_r[head_r] <= 1'b0;
                    ready_r[head_r] <= 1'b0;
                    head_r          <= ptr_inc(head_r);
                    case (type_r[head_r])
                        TYPE_REG: begin
                            commit_r         <= 1'b1;
                            commit_rd_r      <= rd_r[head_r];
                            commit_val_r     <= val_r[head_r];
                            commit_rob_pos_r <= head_r;
                        end
                        TYPE_STORE: begin
                            commit_store_r <= 1'b1;
                        end
                        TYPE_BR: begin
                            commit_store_r <= 1'b0;
                        end
                        default: begin
                            commit_r <= 1'b0;
                        end
                    endcase
                end
                count_r <= count_r + {4'd0, issue_ok_s} - {4'd0, retire_s};
            end
        end else begin
            commit_r       <= 1'b0;
            commit_store_r <= 1'b0;
            rollback_r     <= 1'b0;
        end
    end

    assign rob.issue_rob_pos  = tail_r;
    assign rob.rob_full       = (count_r >= FULL_MARK);
    assign rob.rs1_ready      = rs1_ready_s;
    assign rob.rs1_val        = rs1_val_s;
    assign rob.rs2_ready      = rs2_ready_s;
    assign rob.rs2_val        = rs2_val_s;
    assign rob.commit         = commit_r;
    assign rob.commit_rd      = commit_rd_r;
    assign rob.commit_val     = commit_val_r;
    assign rob.commit_rob_pos = commit_rob_pos_r;
    assign rob.commit_store   = commit_store_r;
    assign rob.rollback       = rollback_r;
    assign rob.rollback_pc    = rollback_pc_r;
endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer with a queue-based in-order retirement model checked every cycle.
module tb_reorder_buffer;
    logic clk = 1'b0;
    logic rst;
    logic rdy;

    reorder_buffer_if rif ();
    reorder_buffer #(.ROB_SIZE(16)) dut (.clk(clk), .rst(rst), .rdy(rdy), .rob(rif.slave));

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  pos;
        logic [4:0]  rd;
        logic [1:0]  typ;
        logic        pred;
        logic [31:0] pc;
        logic        done;
        logic [31:0] val;
        logic        jmp;
        logic [31:0] tgt;
    } ent_t;

    ent_t        q[$];
    int          m_head;
    logic        m_rb;
    logic        m_known;
    logic        m_was_rst;
    logic        e_commit, e_store, e_rb;
    logic [4:0]  e_rd;
    logic [31:0] e_val, e_rbpc;
    logic [3:0]  e_pos;
    int          n_cmp = 0;
    int          n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic look(input logic [3:0] p, output logic r, output logic [31:0] v);
        r = 1'b0;
        v = 32'd0;
        foreach (q[i]) begin
            if (q[i].pos == p && q[i].done) begin
                r = 1'b1;
                v = q[i].val;
            end
        end
        if (!r && rif.alu_result && rif.alu_rob_pos == p) begin
            r = 1'b1;
            v = rif.alu_val;
        end else if (!r && rif.lsb_result && rif.lsb_rob_pos == p) begin
            r = 1'b1;
            v = rif.lsb_val;
        end
    endtask

    task automatic model_step();
        ent_t h, n;
        logic ret, rb_now;
        int   sz, tail_old;
        rb_now = m_rb;
        e_commit = 1'b0; e_store = 1'b0; e_rb = 1'b0; m_was_rst = 1'b0;
        if (rst) begin
            q.delete();
            m_head = 0;
            e_rd = 5'd0; e_val = 32'd0; e_pos = 4'd0; e_rbpc = 32'd0;
            m_known = 1'b1; m_was_rst = 1'b1;
        end else if (rdy) begin
            sz = q.size();
            tail_old = (m_head + sz) % 16;
            ret = 1'b0;
            if (sz > 0) ret = q[0].done;
            if (ret) h = q[0];
            if (ret && h.typ == 2'b01 && h.jmp != h.pred) begin
                e_rb = 1'b1;
                e_rbpc = h.jmp ? h.tgt : h.pc + 32'd4;
                q.delete();
                m_head = 0;
            end else begin
                if (!rb_now) begin
                    foreach (q[i]) begin
                        if (rif.alu_result && q[i].pos == rif.alu_rob_pos) begin
                            q[i].done = 1'b1; q[i].val = rif.alu_val;
                            q[i].jmp = rif.alu_jump; q[i].tgt = rif.alu_target_pc;
                        end else if (rif.lsb_result && q[i].pos == rif.lsb_rob_pos) begin
                            q[i].done = 1'b1; q[i].val = rif.lsb_val;
                        end
                    end
                end
                if (ret) begin
                    void'(q.pop_front());
                    m_head = (m_head + 1) % 16;
                    if (h.typ == 2'b00) begin
                        e_commit = 1'b1; e_rd = h.rd; e_val = h.val; e_pos = h.pos;
                    end else if (h.typ == 2'b10) begin
                        e_store = 1'b1;
                    end
                end
                if (rif.issue && sz < 16 && !rb_now) begin
                    n.pos = 4'(tail_old); n.rd = rif.issue_rd; n.typ = rif.issue_type;
                    n.pred = rif.issue_pred_jump; n.pc = rif.issue_pc;
                    n.done = 1'b0; n.val = 32'd0; n.jmp = 1'b0; n.tgt = 32'd0;
                    q.push_back(n);
                end
            end
        end
        m_rb = e_rb;
    endtask

    task automatic tick();
        logic        r;
        logic [31:0] v;
        #1;
        if (m_known) begin
            chk("issue_rob_pos", 32'(rif.issue_rob_pos), 32'((m_head + q.size()) % 16));
            chk("rob_full", 32'(rif.rob_full), 32'(q.size() >= 15));
            look(rif.rs1_rob_pos, r, v);
            chk("rs1_ready", 32'(rif.rs1_ready), 32'(r));
            chk("rs1_val", rif.rs1_val, v);
            look(rif.rs2_rob_pos, r, v);
            chk("rs2_ready", 32'(rif.rs2_ready), 32'(r));
            chk("rs2_val", rif.rs2_val, v);
        end
        model_step();
        @(posedge clk);
        #1;
        chk("commit", 32'(rif.commit), 32'(e_commit));
        chk("commit_store", 32'(rif.commit_store), 32'(e_store));
        chk("rollback", 32'(rif.rollback), 32'(e_rb));
        if (e_commit || m_was_rst) begin
            chk("commit_rd", 32'(rif.commit_rd), 32'(e_rd));
            chk("commit_val", rif.commit_val, e_val);
            chk("commit_rob_pos", 32'(rif.commit_rob_pos), 32'(e_pos));
        end
        if (e_rb || m_was_rst) chk("rollback_pc", rif.rollback_pc, e_rbpc);
        @(negedge clk);
    endtask

    task automatic idle();
        rif.issue = 1'b0; rif.issue_rd = 5'd0; rif.issue_type = 2'b00;
        rif.issue_pred_jump = 1'b0; rif.issue_pc = 32'd0;
        rif.alu_result = 1'b0; rif.alu_rob_pos = 4'd0; rif.alu_val = 32'd0;
        rif.alu_jump = 1'b0; rif.alu_target_pc = 32'd0;
        rif.lsb_result = 1'b0; rif.lsb_rob_pos = 4'd0; rif.lsb_val = 32'd0;
        rif.rs1_rob_pos = 4'd0; rif.rs2_rob_pos = 4'd0;
    endtask

    task automatic iss(input logic [4:0] rd, input logic [1:0] t, input logic p, input logic [31:0] pc);
        rif.issue = 1'b1; rif.issue_rd = rd; rif.issue_type = t;
        rif.issue_pred_jump = p; rif.issue_pc = pc;
    endtask

    task automatic alu(input logic [3:0] pos, input logic [31:0] val, input logic j, input logic [31:0] tgt);
        rif.alu_result = 1'b1; rif.alu_rob_pos = pos; rif.alu_val = val;
        rif.alu_jump = j; rif.alu_target_pc = tgt;
    endtask

    task automatic lsb(input logic [3:0] pos, input logic [31:0] val);
        rif.lsb_result = 1'b1; rif.lsb_rob_pos = pos; rif.lsb_val = val;
    endtask

    task automatic do_reset();
        idle(); rst = 1'b1; tick(); rst = 1'b0;
    endtask

    initial begin
        m_head = 0; m_rb = 1'b0; m_known = 1'b0; m_was_rst = 1'b0;
        rdy = 1'b1; rst = 1'b1;
        idle();
        tick(); tick();
        rst = 1'b0;
        chk("lit_reset_pos", 32'(rif.issue_rob_pos), 32'd0);
        chk("lit_reset_full", 32'(rif.rob_full), 32'd0);

        // Issue, ALU write-back, commit one cycle later.
        iss(5'd5, 2'b00, 1'b0, 32'h1000); tick();
        idle(); alu(4'd0, 32'h1234, 1'b0, 32'd0); tick();
        idle(); tick();
        chk("lit_c1_commit", 32'(rif.commit), 32'd1);
        chk("lit_c1_rd", 32'(rif.commit_rd), 32'd5);
        chk("lit_c1_val", rif.commit_val, 32'h1234);
        chk("lit_c1_pos", 32'(rif.commit_rob_pos), 32'd0);

        for (int i = 1; i <= 4; i++) begin
            idle(); iss(5'(i), 2'b00, 1'b0, 32'(32'h2000 + 4 * i)); tick();
        end
        idle(); alu(4'd4, 32'd7, 1'b0, 32'd0); rif.rs1_rob_pos = 4'd4; #1;
        chk("lit_byp_alu_rdy", 32'(rif.rs1_ready), 32'd1);
        chk("lit_byp_alu_val", rif.rs1_val, 32'd7);
        tick();
        idle(); rif.rs2_rob_pos = 4'd4; rif.rs1_rob_pos = 4'd3; lsb(4'd3, 32'h33); #1;
        chk("lit_stored_val", rif.rs2_val, 32'd7);
        chk("lit_byp_lsb_val", rif.rs1_val, 32'h33);
        tick();
        idle(); alu(4'd1, 32'h11, 1'b0, 32'd0); lsb(4'd1, 32'h99); tick();
        idle(); tick();
        chk("lit_alu_wins", rif.commit_val, 32'h11);
        tick();
        chk("lit_ooo_hold", 32'(rif.commit), 32'd0);
        idle(); alu(4'd2, 32'h22, 1'b0, 32'd0); tick();
        idle(); tick();
        chk("lit_ooo_pos2", 32'(rif.commit_rob_pos), 32'd2);
        tick();
        chk("lit_ooo_pos3", 32'(rif.commit_rob_pos), 32'd3);
        tick(); tick();

        // Store retire with a same-cycle issue, then rdy stall.
        iss(5'd0, 2'b10, 1'b0, 32'h3000); tick();
        idle(); lsb(4'd5, 32'hAA); tick();
        idle(); iss(5'd0, 2'b00, 1'b0, 32'h3004); tick();
        chk("lit_store", 32'(rif.commit_store), 32'd1);
        idle(); alu(4'd6, 32'h55, 1'b0, 32'd0); tick();
        rdy = 1'b0; idle(); iss(5'd7, 2'b00, 1'b0, 32'h3008); alu(4'd6, 32'h66, 1'b0, 32'd0); tick(); tick();
        chk("lit_rdy_low", 32'(rif.commit), 32'd0);
        rdy = 1'b1; idle(); tick();
        chk("lit_rd0_commit", 32'(rif.commit), 32'd1);
        chk("lit_rd0_val", rif.commit_val, 32'h55);

        // Correctly predicted branch, then not-taken mispredict with pc wrap.
        iss(5'd0, 2'b01, 1'b1, 32'h4000); tick();
        idle(); alu(4'd7, 32'd0, 1'b1, 32'h5000); tick();
        idle(); tick();
        chk("lit_br_ok", 32'(rif.rollback), 32'd0);
        iss(5'd0, 2'b01, 1'b1, 32'hFFFF_FFFC); tick();
        idle(); iss(5'd3, 2'b00, 1'b0, 32'h7000); alu(4'd8, 32'd0, 1'b0, 32'hDEAD); tick();
        idle(); tick();
        chk("lit_rb_wrap_pc", rif.rollback_pc, 32'd0);
        tick();

        // Taken mispredict at position 2; inputs ignored while rollback is high.
        do_reset();
        iss(5'd1, 2'b00, 1'b0, 32'h100); tick();
        iss(5'd2, 2'b00, 1'b0, 32'h104); tick();
        iss(5'd0, 2'b01, 1'b0, 32'h200); tick();
        idle(); alu(4'd0, 32'd1, 1'b0, 32'd0); lsb(4'd1, 32'd2); tick();
        idle(); alu(4'd2, 32'd0, 1'b1, 32'h100); tick();
        idle(); tick(); tick();
        chk("lit_rb", 32'(rif.rollback), 32'd1);
        chk("lit_rb_pc", rif.rollback_pc, 32'h100);
        chk("lit_rb_pos", 32'(rif.issue_rob_pos), 32'd0);
        iss(5'd9, 2'b00, 1'b0, 32'h900); alu(4'd0, 32'h5, 1'b0, 32'd0); tick();
        chk("lit_rb_ignore", 32'(rif.issue_rob_pos), 32'd0);
        idle(); tick();

        // Fill to capacity; reset overrides a same-cycle issue.
        do_reset();
        for (int i = 0; i < 15; i++) begin
            idle(); iss(5'(i + 1), 2'b00, 1'b0, 32'(i * 4)); tick();
        end
        chk("lit_full15", 32'(rif.rob_full), 32'd1);
        iss(5'd16, 2'b00, 1'b0, 32'h40); tick();
        chk("lit_16th_pos", 32'(rif.issue_rob_pos), 32'd0);
        iss(5'd17, 2'b00, 1'b0, 32'h44); tick();
        chk("lit_17th_pos", 32'(rif.issue_rob_pos), 32'd0);
        rst = 1'b1; alu(4'd0, 32'h1, 1'b0, 32'd0); tick(); rst = 1'b0;
        chk("lit_rst_full", 32'(rif.rob_full), 32'd0);

        // Tail wrap: drain 15 entries then issue at 15 and 0.
        do_reset();
        for (int i = 0; i < 15; i++) begin
            idle(); iss(5'd1, 2'b00, 1'b0, 32'h0); tick();
        end
        for (int i = 0; i < 15; i++) begin
            idle(); alu(4'(i), 32'(100 + i), 1'b0, 32'd0); tick();
        end
        idle(); tick();
        idle(); iss(5'd2, 2'b00, 1'b0, 32'h500); #1;
        chk("lit_wrap_pos15", 32'(rif.issue_rob_pos), 32'd15);
        tick();
        iss(5'd3, 2'b00, 1'b0, 32'h504); #1;
        chk("lit_wrap_pos0", 32'(rif.issue_rob_pos), 32'd0);
        tick();
        idle(); alu(4'd15, 32'hF, 1'b0, 32'd0); lsb(4'd0, 32'hA0); tick();
        idle(); tick();
        chk("lit_wrap_c15", 32'(rif.commit_rob_pos), 32'd15);
        tick();
        chk("lit_wrap_c0", 32'(rif.commit_rob_pos), 32'd0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
